// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the fifo block. Drains len_i words from
// the FIFO read port into a 3-entry output buffer that hides the FIFO's one-cycle
// read latency, presents them as a valid/ready stream and pulses done_o at the end.
// Optional build macro FIFO_READER_CHECK_EN adds an incrementing-pattern checker
// driving error_o; without it error_o is tied low. Ports are identical in both builds.
//
// Handshake: a stream word transfers on any rising edge where out_valid_o and
// out_ready_i are both high; out_valid_o never depends on out_ready_i, and
// out_data_o is held while out_valid_o && !out_ready_i.
module fifo_reader #(
   parameter int DATA_WIDTH  = 128,
   parameter int COUNT_WIDTH = 32
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start_i,
   input  logic [COUNT_WIDTH-1:0] len_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [COUNT_WIDTH-1:0] count_o,
   output logic                   fifo_rd_en_o,
   input  logic [DATA_WIDTH-1:0]  fifo_rd_data_i,
   input  logic                   fifo_empty_i,
   output logic                   out_valid_o,
   output logic [DATA_WIDTH-1:0]  out_data_o,
   input  logic                   out_ready_i,
   output logic                   error_o
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] len_q, len_d;
   logic [COUNT_WIDTH-1:0] issued_q, issued_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   inflight_q;
   logic [1:0]             occ_q, occ_d;
   logic [1:0]             wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0]  buf_q [3];

   logic start_acc;
   logic rd_en;
   logic push;
   logic pop;

   assign start_acc = (state_q == IDLE) && start_i;
   // Read gating uses only registered state and the FIFO flag; the pop this cycle
   // is deliberately not credited so out_ready_i never reaches fifo_rd_en_o.
   assign rd_en = (state_q == READ) && !fifo_empty_i && (issued_q < len_q) &&
                  (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
   assign push  = inflight_q;
   assign pop   = (occ_q != 2'd0) && out_ready_i;

   // Next-state, counters and buffer occupancy.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      issued_d = issued_q;
      count_d  = count_q;
      occ_d    = occ_q;

      if (start_acc) begin
         len_d    = len_i;
         issued_d = '0;
         count_d  = '0;
      end else begin
         if (rd_en) issued_d = issued_q + 1'b1;
         if (pop)   count_d  = count_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      case (state_q)
         IDLE:  if (start_i) state_d = (len_i == '0) ? DONE : READ;
         READ:  if (rd_en && (issued_d == len_q)) state_d = DRAIN;
         // Look at next-cycle values so DONE follows the last transfer directly.
         DRAIN: if ((occ_d == 2'd0) && !rd_en && (count_d == len_q)) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control registers; reset discards everything including an issued read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         len_q      <= '0;
         issued_q   <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         count_q    <= count_d;
         inflight_q <= rd_en;
         occ_q      <= occ_d;
         if (push) wr_ptr_q <= (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      end
   end

   // Buffer storage captures FIFO data the cycle after each read; needs no reset.
   always_ff @(posedge clock) begin
      if (push) buf_q[wr_ptr_q] <= fifo_rd_data_i;
   end

   assign busy_o       = (state_q != IDLE);
   assign done_o       = (state_q == DONE);
   assign count_o      = count_q;
   assign fifo_rd_en_o = rd_en;
   assign out_valid_o  = (occ_q != 2'd0);
   assign out_data_o   = buf_q[rd_ptr_q];

`ifdef FIFO_READER_CHECK_EN
   logic [DATA_WIDTH-1:0]  first_q;
   logic [COUNT_WIDTH-1:0] pushed_q;
   logic                   error_q;
   logic                   mismatch;

   // Word 0 defines the pattern base; later words must equal base + index.
   assign mismatch = push && (pushed_q != '0) &&
                     (fifo_rd_data_i != (first_q + DATA_WIDTH'(pushed_q)));

   // Pattern checker state; error is sticky until the next accepted start.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         first_q  <= '0;
         pushed_q <= '0;
         error_q  <= 1'b0;
      end else if (start_acc) begin
         pushed_q <= '0;
         error_q  <= 1'b0;
      end else begin
         if (push) begin
            if (pushed_q == '0) first_q <= fifo_rd_data_i;
            pushed_q <= pushed_q + 1'b1;
         end
         if (mismatch) error_q <= 1'b1;
      end
   end

   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

endmodule
